ram_boot_loader: RTL and testbench

- Hardware program loader sitting directly upstream of the CPU's RAM.
- Accepts a byte stream (program image, first byte first), packs it big-endian into 32-bit words, and writes them to RAM through the RAM's MFA/MFC handshake.
- Holds the CPU in clear until the image is fully written, so a bench or board can boot without backdoor memory writes.

---
 rtl/ram_boot_loader_if.sv | 26 ++
 rtl/ram_boot_loader.sv | 117 +++++++++++
 tb/tb_ram_boot_loader.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_boot_loader_if.sv
// Byte-stream and RAM MFA/MFC bus bundle for the boot loader.
// master: the loader (consumes bytes, drives the RAM request).
// slave:  the environment (byte source and RAM responder).
interface ram_boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_last;
    logic              byte_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_rw;
    logic              mem_mfa;
    logic              mem_mfc;

    modport master (
        input  byte_in, byte_valid, byte_last, mem_mfc,
        output byte_ready, mem_addr, mem_wdata, mem_rw, mem_mfa
    );

    modport slave (
        output byte_in, byte_valid, byte_last, mem_mfc,
        input  byte_ready, mem_addr, mem_wdata, mem_rw, mem_mfa
    );
endinterface

// File: rtl/ram_boot_loader.sv
// Program image loader: packs a byte stream big-endian into 32-bit words and
// writes them to RAM over MFA/MFC, holding the CPU in clear until done.
module ram_boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    ram_boot_loader_if.master bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-2:0] words_written
);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] LAST_WORD = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-2:0] WW_ONE    = (ADDR_W-1)'(1);

    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERROR} state_t;

    state_t     state, state_n;
    logic [1:0] k;          // next byte lane to fill (0 = bits 31:24)
    logic       last_seen;  // current word carries the final image byte
    logic       accept;
    logic       can_start;

    assign accept         = (state == COLLECT) && bus.byte_valid;
    assign can_start      = (state == IDLE) || (state == DONE) || (state == ERROR);
    assign bus.byte_ready = (state == COLLECT);
    assign bus.mem_mfa    = (state == WRITE);
    assign bus.mem_rw     = (state != WRITE);
    assign busy           = (state == COLLECT) || (state == WRITE);

    // State register; clr wins over everything, including a pending write.
    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state: a word goes to RAM when full or when it holds the last byte;
    // a completed write at the top word without last means the image overflowed.
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_n = COLLECT;
            COLLECT: if (accept && (k == 2'd3 || bus.byte_last)) state_n = WRITE;
            WRITE: begin
                if (bus.mem_mfc) begin
                    if (last_seen)                      state_n = DONE;
                    else if (bus.mem_addr == LAST_WORD) state_n = ERROR;
                    else                                state_n = COLLECT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: byte packing, address/count advance and sticky status flags.
    always_ff @(posedge clk) begin
        if (clr) begin
            k             <= 2'd0;
            last_seen     <= 1'b0;
            bus.mem_addr  <= BASE;
            bus.mem_wdata <= 32'd0;
            words_written <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            cpu_hold      <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        k             <= 2'd0;
                        last_seen     <= 1'b0;
                        bus.mem_addr  <= BASE;
                        bus.mem_wdata <= 32'd0;
                        words_written <= '0;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        cpu_hold      <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        case (k)
                            2'd0:    bus.mem_wdata[31:24] <= bus.byte_in;
                            2'd1:    bus.mem_wdata[23:16] <= bus.byte_in;
                            2'd2:    bus.mem_wdata[15:8]  <= bus.byte_in;
                            default: bus.mem_wdata[7:0]   <= bus.byte_in;
                        endcase
                        k         <= k + 2'd1;
                        last_seen <= bus.byte_last;
                    end
                end
                WRITE: begin
                    if (bus.mem_mfc) begin
                        words_written <= words_written + WW_ONE;
                        if (last_seen) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (bus.mem_addr == LAST_WORD) begin
                            error <= 1'b1;
                        end else begin
                            bus.mem_addr  <= bus.mem_addr + STEP;
                            bus.mem_wdata <= 32'd0;
                            k             <= 2'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_boot_loader.sv
// Scoreboard bench: directed byte streams push expected RAM writes; monitors
// pop and compare on every completed MFA/MFC write.
module tb_ram_boot_loader;
    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic clr, start8, start4;
    logic hold8, busy8, done8, err8;
    logic hold4, busy4, done4, err4;
    logic [6:0] ww8;
    logic [2:0] ww4;

    int checks = 0;
    int errors = 0;
    int dly8 = 0, dly4 = 0, w8 = 0, w4 = 0;
    wr_t exp8[$];
    wr_t exp4[$];
    logic [7:0] stim[$];

    logic        prev8 = 1'b0, prev4 = 1'b0;
    logic [7:0]  a8, a4;
    logic [31:0] d8, d4;

    always #5 clk = ~clk;

    ram_boot_loader_if #(.ADDR_W(8)) b8();
    ram_boot_loader_if #(.ADDR_W(4)) b4();

    ram_boot_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut8 (
        .clk(clk), .clr(clr), .start(start8), .bus(b8),
        .cpu_hold(hold8), .busy(busy8), .done(done8), .error(err8),
        .words_written(ww8)
    );

    ram_boot_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
        .clk(clk), .clr(clr), .start(start4), .bus(b4),
        .cpu_hold(hold4), .busy(busy4), .done(done4), .error(err4),
        .words_written(ww4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_in(input bit sel, input logic [7:0] b, input logic v, input logic l);
        if (sel) begin b4.byte_in = b; b4.byte_valid = v; b4.byte_last = l; end
        else     begin b8.byte_in = b; b8.byte_valid = v; b8.byte_last = l; end
    endtask

    task automatic pulse_start(input bit sel);
        @(posedge clk); #1;
        if (sel) start4 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; start8 = 1'b0;
    endtask

    // Offer every byte of stim; each must be accepted within a cycle budget.
    task automatic drive(input bit sel, input bit toggle, input bit mark_last);
        logic r;
        bit   acc;
        for (int i = 0; i < stim.size(); i++) begin
            set_in(sel, stim[i], 1'b1, mark_last && (i == stim.size() - 1));
            acc = 1'b0;
            for (int c = 0; c < 200 && !acc; c++) begin
                @(negedge clk);
                r = sel ? b4.byte_ready : b8.byte_ready;
                @(posedge clk); #1;
                acc = r;
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL byte_accept actual=timeout required=accept byte %0d", i);
            end
            set_in(sel, 8'h00, 1'b0, 1'b0);
            if (toggle) begin @(posedge clk); #1; end
        end
    endtask

    // Bounded wait, sampled on the falling edge: 0=done8, 1=err4, 2=mfa8.
    task automatic wait_sig(input int which, input string name);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            @(negedge clk);
            case (which)
                0:       hit = done8;
                1:       hit = err4;
                default: hit = b8.mem_mfa;
            endcase
        end
        chk(name, 32'(hit), 32'd1);
    endtask

    task automatic push8(input logic [7:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        exp8.push_back(w);
    endtask

    task automatic push4(input logic [7:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        exp4.push_back(w);
    endtask

    // RAM responder for the 8-bit instance: MFC after dly8 cycles of MFA, one cycle wide.
    initial begin
        b8.mem_mfc = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (b8.mem_mfc) b8.mem_mfc = 1'b0;
            else if (b8.mem_mfa === 1'b1 && !clr) begin
                if (w8 >= dly8) begin b8.mem_mfc = 1'b1; w8 = 0; end
                else w8++;
            end else w8 = 0;
        end
    end

    // RAM responder for the 4-bit instance.
    initial begin
        b4.mem_mfc = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (b4.mem_mfc) b4.mem_mfc = 1'b0;
            else if (b4.mem_mfa === 1'b1 && !clr) begin
                if (w4 >= dly4) begin b4.mem_mfc = 1'b1; w4 = 0; end
                else w4++;
            end else w4 = 0;
        end
    end

    // Monitor 8: bus stability during WRITE and scoreboard pop on completion.
    always @(negedge clk) begin
        if (clr !== 1'b0) prev8 = 1'b0;
        else begin
            if (b8.mem_mfa === 1'b1) begin
                if (!prev8) begin a8 = b8.mem_addr; d8 = b8.mem_wdata; end
                else begin
                    chk("w8_addr_stable", 32'(b8.mem_addr), 32'(a8));
                    chk("w8_data_stable", b8.mem_wdata, d8);
                end
                chk("w8_ready_low", 32'(b8.byte_ready), 32'd0);
                chk("w8_rw_low", 32'(b8.mem_rw), 32'd0);
                if (b8.mem_mfc === 1'b1) begin
                    if (exp8.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL w8_unexpected actual=%h@%h required=none", b8.mem_wdata, b8.mem_addr);
                    end else begin
                        wr_t e;
                        e = exp8.pop_front();
                        chk("w8_addr", 32'(b8.mem_addr), 32'(e.addr));
                        chk("w8_data", b8.mem_wdata, e.data);
                    end
                end
            end
            prev8 = (b8.mem_mfa === 1'b1);
        end
    end

    // Monitor 4: same checks for the small-capacity instance.
    always @(negedge clk) begin
        if (clr !== 1'b0) prev4 = 1'b0;
        else begin
            if (b4.mem_mfa === 1'b1) begin
                if (!prev4) begin a4 = 8'(b4.mem_addr); d4 = b4.mem_wdata; end
                else begin
                    chk("w4_addr_stable", 32'(b4.mem_addr), 32'(a4));
                    chk("w4_data_stable", b4.mem_wdata, d4);
                end
                chk("w4_ready_low", 32'(b4.byte_ready), 32'd0);
                if (b4.mem_mfc === 1'b1) begin
                    if (exp4.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL w4_unexpected actual=%h@%h required=none", b4.mem_wdata, b4.mem_addr);
                    end else begin
                        wr_t e;
                        e = exp4.pop_front();
                        chk("w4_addr", 32'(b4.mem_addr), 32'(e.addr));
                        chk("w4_data", b4.mem_wdata, e.data);
                    end
                end
            end
            prev4 = (b4.mem_mfa === 1'b1);
        end
    end

    initial begin
        clr = 1'b1; start8 = 1'b0; start4 = 1'b0;
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        set_in(1'b1, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold", 32'(hold8), 32'd1);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_error", 32'(err8), 32'd0);
        chk("rst_mfa", 32'(b8.mem_mfa), 32'd0);
        chk("rst_rw", 32'(b8.mem_rw), 32'd1);
        chk("rst_addr", 32'(b8.mem_addr), 32'd0);
        chk("rst_wdata", b8.mem_wdata, 32'd0);
        chk("rst_ww", 32'(ww8), 32'd0);
        chk("rst_ready", 32'(b8.byte_ready), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_hold4", 32'(hold4), 32'd1);
        clr = 1'b0;

        // Single full word, MFC one cycle after MFA.
        dly8 = 1;
        pulse_start(1'b0);
        chk("collect_busy", 32'(busy8), 32'd1);
        stim = '{8'hE3, 8'hA0, 8'h10, 8'h04};
        push8(8'h00, 32'hE3A01004);
        drive(1'b0, 1'b0, 1'b1);
        wait_sig(0, "t1_done_wait");
        chk("t1_done", 32'(done8), 32'd1);
        chk("t1_hold", 32'(hold8), 32'd0);
        chk("t1_ww", 32'(ww8), 32'd1);
        chk("t1_busy", 32'(busy8), 32'd0);

        // Six bytes: one full word plus a zero-padded partial word, MFC same cycle.
        dly8 = 0;
        pulse_start(1'b0);
        chk("t2_done_cleared", 32'(done8), 32'd0);
        chk("t2_hold_set", 32'(hold8), 32'd1);
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        push8(8'h00, 32'h01020304);
        push8(8'h04, 32'h05060000);
        drive(1'b0, 1'b0, 1'b1);
        wait_sig(0, "t2_done_wait");
        chk("t2_ww", 32'(ww8), 32'd2);
        chk("t2_hold", 32'(hold8), 32'd0);

        // Same image with gappy valid and slow memory.
        dly8 = 5;
        pulse_start(1'b0);
        push8(8'h00, 32'h01020304);
        push8(8'h04, 32'h05060000);
        drive(1'b0, 1'b1, 1'b1);
        wait_sig(0, "t3_done_wait");
        chk("t3_ww", 32'(ww8), 32'd2);
        chk("t3_done", 32'(done8), 32'd1);

        // 16-byte capacity: four words fill it, then overflow error.
        dly4 = 0;
        pulse_start(1'b1);
        stim = {};
        for (int i = 1; i <= 16; i++) stim.push_back(8'(i));
        push4(8'h00, 32'h01020304);
        push4(8'h04, 32'h05060708);
        push4(8'h08, 32'h090A0B0C);
        push4(8'h0C, 32'h0D0E0F10);
        drive(1'b1, 1'b0, 1'b0);
        wait_sig(1, "t4_error_wait");
        chk("t4_error", 32'(err4), 32'd1);
        chk("t4_hold", 32'(hold4), 32'd1);
        chk("t4_done", 32'(done4), 32'd0);
        chk("t4_busy", 32'(busy4), 32'd0);
        chk("t4_ww", 32'(ww4), 32'd4);
        set_in(1'b1, 8'h11, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t4_excess_ready", 32'(b4.byte_ready), 32'd0);
            if (i == 7) set_in(1'b1, 8'h14, 1'b1, 1'b1);
        end
        set_in(1'b1, 8'h00, 1'b0, 1'b0);
        chk("t4_error_sticky", 32'(err4), 32'd1);

        // Abort during WRITE with MFC withheld, then a clean reload.
        dly8 = 1000;
        pulse_start(1'b0);
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        drive(1'b0, 1'b0, 1'b0);
        wait_sig(2, "t5_mfa_wait");
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_mfa_dropped", 32'(b8.mem_mfa), 32'd0);
        chk("t5_ww", 32'(ww8), 32'd0);
        chk("t5_busy", 32'(busy8), 32'd0);
        chk("t5_hold", 32'(hold8), 32'd1);
        chk("t5_addr", 32'(b8.mem_addr), 32'd0);
        clr = 1'b0;
        dly8 = 0;
        pulse_start(1'b0);
        stim = '{8'hAA, 8'hBB, 8'hCC};
        push8(8'h00, 32'hAABBCC00);
        drive(1'b0, 1'b0, 1'b1);
        wait_sig(0, "t5_done_wait");
        chk("t5_reload_ww", 32'(ww8), 32'd1);
        chk("t5_reload_hold", 32'(hold8), 32'd0);

        repeat (3) @(posedge clk);
        chk("sb8_drained", 32'(exp8.size()), 32'd0);
        chk("sb4_drained", 32'(exp4.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
